// File: rtl/crc_byte_feeder_pkg.sv
// Shared definitions for the CRC byte feeder: default sizes, the FIFO entry
// layout and the pointer-width helper.
package crc_byte_feeder_pkg;

    // Default FIFO depth (power of two, 2..16) and frame counter width.
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // One stored entry: end-of-frame mark above the data byte.
    localparam int ENTRY_W = 9;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    // Pointer width for a FIFO of the given depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/crc_byte_feeder_byte_fifo.sv
// Byte FIFO with per-entry end-of-frame mark, registered full flag and a
// sticky overflow flag for writes dropped while full.
module byte_fifo
    import crc_byte_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        wr_en_i,
    input  fifo_entry_t wr_entry_i,
    input  logic        rd_ready_i,
    input  logic        clr_overflow_i,
    output logic        full_o,
    output logic        valid_o,
    output fifo_entry_t head_o,
    output logic        pop_o,
    output logic        overflow_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               push, pop, drop;

    // Transfer qualification; full is the registered flag, so a pop in the
    // same cycle never rescues a write into a full FIFO. Flush masks both.
    always_comb begin
        push = wr_en_i && !full_q && !flush_i;
        pop  = (count_q != '0) && rd_ready_i && !flush_i;
        drop = wr_en_i && full_q && !flush_i;
    end

    // Next-state for pointers, occupancy, full and overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == FULL_CNT);
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop)                ovf_d = 1'b1;
        else if (clr_overflow_i) ovf_d = 1'b0;
        else                     ovf_d = ovf_q;
    end

    // State registers; reset also clears storage so the head reads zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            if (push) mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

    // Head is read straight out of storage; no bypass from the write side.
    always_comb begin
        valid_o    = (count_q != '0);
        head_o     = fifo_entry_t'(mem_q[rd_ptr_q]);
        pop_o      = pop;
        full_o     = full_q;
        overflow_o = ovf_q;
    end

endmodule

// File: rtl/crc_byte_feeder.sv
// Byte-stream buffer in front of the CRC-32 compute port: queues producer
// bytes, presents them on valid/ready, and measures completed frame lengths.
module crc_byte_feeder
    import crc_byte_feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_last_i,
    output logic             wr_full_o,
    input  logic             flush_i,
    output logic             out_valid_o,
    output logic [7:0]       out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] frame_len_o,
    output logic             frame_done_o,
    output logic             overflow_o,
    input  logic             clr_overflow_i
);

    fifo_entry_t      wr_entry;
    fifo_entry_t      head;
    logic             pop;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_q, done_d;

    // Pack the producer byte with its frame mark.
    always_comb begin
        wr_entry.last = wr_last_i;
        wr_entry.data = wr_data_i;
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .wr_en_i        (wr_en_i),
        .wr_entry_i     (wr_entry),
        .rd_ready_i     (out_ready_i),
        .clr_overflow_i (clr_overflow_i),
        .full_o         (wr_full_o),
        .valid_o        (out_valid_o),
        .head_o         (head),
        .pop_o          (pop),
        .overflow_o     (overflow_o)
    );

    // Frame counter next-state: saturating count of pops, closed out by the
    // pop of a last-marked byte. Flush drops the partial count.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (flush_i) begin
            cnt_d = '0;
        end else if (pop) begin
            if (head.last) begin
                len_d  = cnt_inc;
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Frame tracking registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            done_q <= done_d;
        end
    end

    // Output mapping.
    always_comb begin
        out_data_o   = head.data;
        out_last_o   = head.last;
        frame_len_o  = len_q;
        frame_done_o = done_q;
    end

endmodule

// File: tb/tb_crc_byte_feeder.sv
// Self-checking bench for crc_byte_feeder: scoreboard of queued bytes checked
// on every pop, a bit-serial CRC-32 model acting as the downstream engine,
// and one task per scenario.
module tb_crc_byte_feeder;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        wr_full;
    logic        flush;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic [15:0] frame_len;
    logic        frame_done;
    logic        overflow;
    logic        clr_overflow;

    int          total = 0;
    int          bad   = 0;
    logic [8:0]  exp_q [$];
    logic [31:0] crc_acc;
    int          done_cnt = 0;
    logic [15:0] last_len = '0;

    crc_byte_feeder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .wr_last_i      (wr_last),
        .wr_full_o      (wr_full),
        .flush_i        (flush),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .out_last_o     (out_last),
        .out_ready_i    (out_ready),
        .frame_len_o    (frame_len),
        .frame_done_o   (frame_done),
        .overflow_o     (overflow),
        .clr_overflow_i (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Scoreboard: every pop seen by the consumer is matched against the
    // oldest expected byte and fed to the CRC model; frame_done pulses are
    // counted cycle by cycle.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && !flush && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra_pop got=%b_%02h want=none", out_last, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    bad++;
                    $display("FAIL sb_pop got=%b_%02h want=%b_%02h", out_last, out_data, e[8], e[7:0]);
                end
            end
            crc_acc = crc_step(crc_acc, out_data);
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            last_len = frame_len;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (wr_full !== 1'b0)     begin bad++; $display("FAIL rst_wr_full got=%b want=0", wr_full); end
        total++; if (frame_len !== 16'h0)  begin bad++; $display("FAIL rst_frame_len got=%0d want=0", frame_len); end
        total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
        total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
        total++; if (out_data !== 8'h00)   begin bad++; $display("FAIL rst_out_data got=%02h want=00", out_data); end
        step();
    endtask

    task automatic test_crc_frame();
        int d0;
        d0 = done_cnt;
        crc_acc = 32'hFFFFFFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en   = (i < 9);
            wr_data = 8'h31 + 8'(i);
            wr_last = (i == 8);
            if (i < 9) exp_q.push_back({wr_last, wr_data});
            @(negedge clk);
            if (i == 0) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL crc_no_bypass got=%b want=0", out_valid); end
            end
            if (i == 1) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL crc_latency got=%b want=1", out_valid); end
            end
            step();
        end
        wr_en = 1'b0; wr_last = 1'b0;
        total++; if (done_cnt - d0 !== 1)        begin bad++; $display("FAIL crc_done_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (last_len !== 16'd9)         begin bad++; $display("FAIL crc_frame_len got=%0d want=9", last_len); end
        total++; if (~crc_acc !== 32'hCBF43926)  begin bad++; $display("FAIL crc_result got=%08h want=cbf43926", ~crc_acc); end
        total++; if (exp_q.size() !== 0)         begin bad++; $display("FAIL crc_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'hA0 + 8'(i);
            wr_last = (i == 7);
            if (i < 8) exp_q.push_back({wr_last, wr_data});
            @(negedge clk);
            if (i == 8) begin
                total++; if (wr_full !== 1'b1)  begin bad++; $display("FAIL ovf_full_after_8 got=%b want=1", wr_full); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
            end
            step();
        end
        wr_en = 1'b0; wr_last = 1'b0;
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        total++; if (wr_full !== 1'b1)  begin bad++; $display("FAIL ovf_still_full got=%b want=1", wr_full); end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (wr_full !== 1'b1) begin bad++; $display("FAIL ovf_full_before_pop got=%b want=1", wr_full); end
        step();
        @(negedge clk);
        total++; if (wr_full !== 1'b0) begin bad++; $display("FAIL ovf_full_release got=%b want=0", wr_full); end
        repeat (9) step();
        @(negedge clk);
        total++; if (exp_q.size() !== 0)  begin bad++; $display("FAIL ovf_drain got=%0d want=0", exp_q.size()); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL ovf_empty got=%b want=0", out_valid); end
        total++; if (last_len !== 16'd8)  begin bad++; $display("FAIL ovf_frame_len got=%0d want=8", last_len); end
        total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        out_ready = 1'b0;
        step();
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        @(negedge clk);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        step();
    endtask

    task automatic test_full_pushpop();
        int d0;
        d0 = done_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'hB0 + 8'(i); wr_last = 1'b0;
            exp_q.push_back({wr_last, wr_data});
            step();
        end
        // Push against a full FIFO while popping: push dropped, pop taken.
        wr_en = 1'b1; wr_data = 8'hEE; out_ready = 1'b1;
        @(negedge clk);
        total++; if (wr_full !== 1'b1) begin bad++; $display("FAIL pp_full got=%b want=1", wr_full); end
        step();
        wr_en = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pp_overflow got=%b want=1", overflow); end
        total++; if (wr_full !== 1'b0)  begin bad++; $display("FAIL pp_occ7 got=%b want=0", wr_full); end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); wr_last = (i == 19); out_ready = 1'b1;
            exp_q.push_back({wr_last, wr_data});
            step();
        end
        wr_en = 1'b0; wr_last = 1'b0;
        repeat (10) step();
        @(negedge clk);
        total++; if (exp_q.size() !== 0)  begin bad++; $display("FAIL pp_drain got=%0d want=0", exp_q.size()); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL pp_no_drop got=%b want=0", overflow); end
        total++; if (last_len !== 16'd28) begin bad++; $display("FAIL pp_frame_len got=%0d want=28", last_len); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL pp_done got=%0d want=1", done_cnt - d0); end
        step();
    endtask

    task automatic test_flush();
        int d0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hD0 + 8'(i); wr_last = 1'b0;
            exp_q.push_back({wr_last, wr_data});
            step();
        end
        wr_en = 1'b0; out_ready = 1'b1;
        step();
        step();
        // Flush alongside a write and a ready: both must be ignored.
        d0 = done_cnt;
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
        exp_q.delete();
        step();
        flush = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL fl_out_valid got=%b want=0", out_valid); end
        total++; if (frame_len !== 16'd28) begin bad++; $display("FAIL fl_frame_len got=%0d want=28", frame_len); end
        total++; if (done_cnt !== d0)      begin bad++; $display("FAIL fl_done got=%0d want=%0d", done_cnt, d0); end
        total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL fl_overflow got=%b want=0", overflow); end
        step();
        for (int i = 0; i < 8; i++) begin
            wr_en = (i < 3); wr_data = 8'hE0 + 8'(i); wr_last = (i == 2); out_ready = 1'b1;
            if (i < 3) exp_q.push_back({wr_last, wr_data});
            step();
        end
        wr_en = 1'b0; wr_last = 1'b0;
        total++; if (last_len !== 16'd3)  begin bad++; $display("FAIL fl_new_len got=%0d want=3", last_len); end
        total++; if (exp_q.size() !== 0)  begin bad++; $display("FAIL fl_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int d0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'hF0 + 8'(i); wr_last = 1'b0;
            exp_q.push_back({wr_last, wr_data});
            step();
        end
        d0 = done_cnt;
        rst = 1'b1; wr_data = 8'hF5;
        exp_q.delete();
        step();
        @(negedge clk);
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rm_out_valid got=%b want=0", out_valid); end
        total++; if (wr_full !== 1'b0)    begin bad++; $display("FAIL rm_wr_full got=%b want=0", wr_full); end
        total++; if (out_data !== 8'h00)  begin bad++; $display("FAIL rm_out_data got=%02h want=00", out_data); end
        total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL rm_out_last got=%b want=0", out_last); end
        total++; if (frame_len !== 16'h0) begin bad++; $display("FAIL rm_frame_len got=%0d want=0", frame_len); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rm_frame_done got=%b want=0", frame_done); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rm_overflow got=%b want=0", overflow); end
        step();
        rst = 1'b0; wr_en = 1'b0;
        repeat (3) step();
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL rm_partial_done got=%0d want=%0d", done_cnt, d0); end
        for (int i = 0; i < 6; i++) begin
            wr_en = (i < 2); wr_data = 8'h11 + 8'(i); wr_last = (i == 1);
            if (i < 2) exp_q.push_back({wr_last, wr_data});
            step();
        end
        wr_en = 1'b0; wr_last = 1'b0;
        total++; if (last_len !== 16'd2)      begin bad++; $display("FAIL rm_new_len got=%0d want=2", last_len); end
        total++; if (done_cnt - d0 !== 1)     begin bad++; $display("FAIL rm_new_done got=%0d want=1", done_cnt - d0); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_last = 1'b0;
        flush = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
        crc_acc = 32'hFFFFFFFF;
        test_reset();
        test_crc_frame();
        test_overflow();
        test_full_pushpop();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
